// File: rtl/y86_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : y86_pkg
// Brief    : Shared Y86-64 widths, types and register specifier constants.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package y86_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 4;

    typedef logic [ADDR_W-1:0] reg_id_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam reg_id_t RAX   = 4'h0;
    localparam reg_id_t RCX   = 4'h1;
    localparam reg_id_t RDX   = 4'h2;
    localparam reg_id_t RBX   = 4'h3;
    localparam reg_id_t RSP   = 4'h4;
    localparam reg_id_t RBP   = 4'h5;
    localparam reg_id_t RSI   = 4'h6;
    localparam reg_id_t RDI   = 4'h7;
    localparam reg_id_t R8    = 4'h8;
    localparam reg_id_t R9    = 4'h9;
    localparam reg_id_t R10   = 4'hA;
    localparam reg_id_t R11   = 4'hB;
    localparam reg_id_t R12   = 4'hC;
    localparam reg_id_t R13   = 4'hD;
    localparam reg_id_t R14   = 4'hE;
    localparam reg_id_t RNONE = 4'hF;

endpackage
`default_nettype wire

// File: rtl/reg_file_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : reg_file_if
// Brief    : Decode/write-back bus between the SEQ datapath and the register file.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface reg_file_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 4
);
    logic              wb_en;
    logic [ADDR_W-1:0] dstE;
    logic [DATA_W-1:0] valE;
    logic [ADDR_W-1:0] dstM;
    logic [DATA_W-1:0] valM;
    logic [ADDR_W-1:0] srcA;
    logic [ADDR_W-1:0] srcB;
    logic [DATA_W-1:0] valA;
    logic [DATA_W-1:0] valB;

    modport master (
        output wb_en, dstE, valE, dstM, valM, srcA, srcB,
        input  valA, valB
    );

    modport slave (
        input  wb_en, dstE, valE, dstM, valM, srcA, srcB,
        output valA, valB
    );
endinterface
`default_nettype wire

// File: rtl/reg_read_port.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : reg_read_port
// Brief    : Combinational register read mux with optional write-through bypass.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module reg_read_port #(
    parameter int                DATA_W = 64,
    parameter int                ADDR_W = 4,
    parameter int                NREG   = 15,
    parameter logic [ADDR_W-1:0] RNONE  = 4'hF,
    parameter bit                BYPASS = 1'b0
) (
    input  logic [ADDR_W-1:0] sel,
    input  logic [DATA_W-1:0] regs [NREG],
    input  logic              we_e,
    input  logic [ADDR_W-1:0] dst_e,
    input  logic [DATA_W-1:0] val_e,
    input  logic              we_m,
    input  logic [ADDR_W-1:0] dst_m,
    input  logic [DATA_W-1:0] val_m,
    output logic [DATA_W-1:0] val
);
    import y86_pkg::*;

    logic [DATA_W-1:0] w_stored;

    // RNONE matches no entry, so it falls through to zero.
    always_comb begin
        w_stored = '0;
        for (int i = 0; i < NREG; i++) begin
            if (sel == ADDR_W'(i)) w_stored = regs[i];
        end
    end

    // M is checked first so a dual write to one register forwards valM.
    always_comb begin
        val = w_stored;
        if (BYPASS && sel != RNONE) begin
            if (we_m && dst_m == sel)      val = val_m;
            else if (we_e && dst_e == sel) val = val_e;
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : reg_file
// Brief    : Y86-64 program register file, two read ports, E/M write ports.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module reg_file #(
    parameter int                DATA_W   = y86_pkg::DATA_W,
    parameter int                ADDR_W   = y86_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RNONE    = y86_pkg::RNONE,
    parameter logic [DATA_W-1:0] RSP_INIT = '0,
    parameter bit                BYPASS   = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    reg_file_if.slave         bus,
    input  logic [ADDR_W-1:0] dbg_sel,
    output logic [DATA_W-1:0] dbg_val,
    output logic [15:0]       wr_count
);
    import y86_pkg::*;

    localparam int c_NREG = 15;

    logic [DATA_W-1:0] r_regs [c_NREG];
    logic [15:0]       r_count;
    logic              w_we_e;
    logic              w_we_m;
    logic [1:0]        w_inc;

    assign w_we_e = bus.wb_en && !rst && (bus.dstE != RNONE);
    assign w_we_m = bus.wb_en && !rst && (bus.dstM != RNONE);

    // Both ports on one register count as a single committed write.
    always_comb begin
        w_inc = 2'(w_we_e) + 2'(w_we_m);
        if (w_we_e && w_we_m && (bus.dstE == bus.dstM)) w_inc = 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_NREG; i++) begin
                r_regs[i] <= (ADDR_W'(i) == ADDR_W'(RSP)) ? RSP_INIT : '0;
            end
            r_count <= '0;
        end else begin
            for (int i = 0; i < c_NREG; i++) begin
                if (w_we_m && bus.dstM == ADDR_W'(i))      r_regs[i] <= bus.valM;
                else if (w_we_e && bus.dstE == ADDR_W'(i)) r_regs[i] <= bus.valE;
            end
            r_count <= r_count + 16'(w_inc);
        end
    end

    assign wr_count = r_count;

    reg_read_port #(
        .DATA_W (DATA_W), .ADDR_W (ADDR_W), .NREG (c_NREG),
        .RNONE  (RNONE),  .BYPASS (BYPASS)
    ) u_port_a (
        .sel   (bus.srcA), .regs  (r_regs),
        .we_e  (w_we_e),   .dst_e (bus.dstE), .val_e (bus.valE),
        .we_m  (w_we_m),   .dst_m (bus.dstM), .val_m (bus.valM),
        .val   (bus.valA)
    );

    reg_read_port #(
        .DATA_W (DATA_W), .ADDR_W (ADDR_W), .NREG (c_NREG),
        .RNONE  (RNONE),  .BYPASS (BYPASS)
    ) u_port_b (
        .sel   (bus.srcB), .regs  (r_regs),
        .we_e  (w_we_e),   .dst_e (bus.dstE), .val_e (bus.valE),
        .we_m  (w_we_m),   .dst_m (bus.dstM), .val_m (bus.valM),
        .val   (bus.valB)
    );

    reg_read_port #(
        .DATA_W (DATA_W), .ADDR_W (ADDR_W), .NREG (c_NREG),
        .RNONE  (RNONE),  .BYPASS (1'b0)
    ) u_port_dbg (
        .sel   (dbg_sel), .regs  (r_regs),
        .we_e  (1'b0),    .dst_e (RNONE), .val_e ('0),
        .we_m  (1'b0),    .dst_m (RNONE), .val_m ('0),
        .val   (dbg_val)
    );

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_reg_file
// Brief    : Directed self-checking bench, bypassed and non-bypassed copies.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_reg_file;

    localparam logic [63:0] c_RSP_INIT = 64'h200;

    logic        clk;
    logic        rst;
    logic        wb_en;
    logic [3:0]  dstE, dstM, srcA, srcB, dbg_sel;
    logic [63:0] valE, valM;
    logic [63:0] dbg_b, dbg_n;
    logic [15:0] cnt_b, cnt_n;

    int n_vec  = 0;
    int n_miss = 0;

    reg_file_if #(.DATA_W(64), .ADDR_W(4)) bus_b ();
    reg_file_if #(.DATA_W(64), .ADDR_W(4)) bus_n ();

    assign bus_b.wb_en = wb_en; assign bus_n.wb_en = wb_en;
    assign bus_b.dstE  = dstE;  assign bus_n.dstE  = dstE;
    assign bus_b.valE  = valE;  assign bus_n.valE  = valE;
    assign bus_b.dstM  = dstM;  assign bus_n.dstM  = dstM;
    assign bus_b.valM  = valM;  assign bus_n.valM  = valM;
    assign bus_b.srcA  = srcA;  assign bus_n.srcA  = srcA;
    assign bus_b.srcB  = srcB;  assign bus_n.srcB  = srcB;

    reg_file #(.RSP_INIT(c_RSP_INIT), .BYPASS(1'b1)) u_dut_byp (
        .clk (clk), .rst (rst), .bus (bus_b),
        .dbg_sel (dbg_sel), .dbg_val (dbg_b), .wr_count (cnt_b)
    );

    reg_file #(.RSP_INIT(c_RSP_INIT), .BYPASS(1'b0)) u_dut_nob (
        .clk (clk), .rst (rst), .bus (bus_n),
        .dbg_sel (dbg_sel), .dbg_val (dbg_n), .wr_count (cnt_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        wb_en = 1'b0; dstE = 4'hF; dstM = 4'hF; valE = '0; valM = '0;
    endtask

    // One rising edge, then return the write inputs to idle and let reads settle.
    task automatic step();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        #1;
    endtask

    initial begin
        rst = 1'b1; srcA = 4'h0; srcB = 4'h0; dbg_sel = 4'h0;
        idle();
        step();

        for (int i = 0; i < 15; i++) begin
            srcA = 4'(i); srcB = 4'(i); #1;
            check("rst_valA_nob", bus_n.valA, (i == 4) ? c_RSP_INIT : 64'h0);
            check("rst_valB_byp", bus_b.valB, (i == 4) ? c_RSP_INIT : 64'h0);
        end
        check("rst_cnt_b", {48'h0, cnt_b}, 64'h0);
        check("rst_cnt_n", {48'h0, cnt_n}, 64'h0);
        dbg_sel = 4'h4; #1;
        check("rst_dbg_rsp", dbg_n, c_RSP_INIT);

        // Dual write on distinct registers
        @(negedge clk);
        wb_en = 1'b1; dstE = 4'h2; valE = 64'hAA; dstM = 4'h3; valM = 64'hBB;
        srcA = 4'h2; srcB = 4'h3; #1;
        check("dual_pre_nob_A", bus_n.valA, 64'h0);
        check("dual_pre_byp_A", bus_b.valA, 64'hAA);
        check("dual_pre_byp_B", bus_b.valB, 64'hBB);
        step();
        check("dual_nob_A", bus_n.valA, 64'hAA);
        check("dual_nob_B", bus_n.valB, 64'hBB);
        check("dual_byp_A", bus_b.valA, 64'hAA);
        check("dual_cnt", {48'h0, cnt_n}, 64'd2);

        // E/M conflict on %rsp: M wins, one write counted
        @(negedge clk);
        wb_en = 1'b1; dstE = 4'h4; valE = 64'h1F8; dstM = 4'h4; valM = 64'h55;
        srcA = 4'h4; #1;
        check("conf_pre_byp", bus_b.valA, 64'h55);
        check("conf_pre_nob", bus_n.valA, c_RSP_INIT);
        step();
        check("conf_nob", bus_n.valA, 64'h55);
        check("conf_cnt", {48'h0, cnt_n}, 64'd3);

        // Writes to RNONE are dropped; RNONE reads zero
        @(negedge clk);
        wb_en = 1'b1; dstE = 4'hF; valE = 64'hDEAD; dstM = 4'hF; valM = 64'hBEEF;
        srcA = 4'hF; srcB = 4'h2; #1;
        check("rnone_pre_byp", bus_b.valA, 64'h0);
        step();
        check("rnone_nob_A", bus_n.valA, 64'h0);
        check("rnone_keep2", bus_n.valB, 64'hAA);
        check("rnone_cnt", {48'h0, cnt_n}, 64'd3);

        // wb_en=0 blocks writes and bypass
        @(negedge clk);
        wb_en = 1'b0; dstE = 4'h1; valE = 64'h123; srcA = 4'h1; #1;
        check("gate_pre_byp", bus_b.valA, 64'h0);
        step();
        check("gate_nob", bus_n.valA, 64'h0);
        check("gate_cnt", {48'h0, cnt_b}, 64'd3);

        // Same-cycle read of a register being written
        @(negedge clk);
        wb_en = 1'b1; dstE = 4'h5; valE = 64'h77; srcA = 4'h5; dbg_sel = 4'h5; #1;
        check("byp_A", bus_b.valA, 64'h77);
        check("nob_A_old", bus_n.valA, 64'h0);
        check("byp_dbg_nobyp", dbg_b, 64'h0);
        step();
        check("byp_after_nob", bus_n.valA, 64'h77);
        check("byp_after_dbg", dbg_b, 64'h77);
        check("byp_cnt", {48'h0, cnt_b}, 64'd4);

        // Reset overrides a concurrent write
        @(negedge clk);
        rst = 1'b1; wb_en = 1'b1; dstE = 4'h6; valE = 64'h9; srcA = 4'h6; srcB = 4'h4; #1;
        check("rst_w_pre_byp", bus_b.valA, 64'h0);
        step();
        check("rst_w_reg6", bus_n.valA, 64'h0);
        check("rst_w_rsp", bus_n.valB, c_RSP_INIT);
        check("rst_w_cnt", {48'h0, cnt_n}, 64'h0);
        srcA = 4'h5; #1;
        check("rst_w_reg5", bus_b.valA, 64'h0);

        // Counter wrap: 32767 dual writes, one single, one dual
        for (int k = 0; k < 32767; k++) begin
            @(negedge clk);
            wb_en = 1'b1; dstE = 4'h7; valE = 64'(k); dstM = 4'h8; valM = 64'(k + 1);
        end
        step();
        check("wrap_fffe", {48'h0, cnt_n}, 64'hFFFE);
        srcA = 4'h7; srcB = 4'h8; #1;
        check("wrap_r7", bus_n.valA, 64'd32766);
        check("wrap_r8", bus_n.valB, 64'd32767);
        @(negedge clk);
        wb_en = 1'b1; dstE = 4'h9; valE = 64'h1;
        step();
        check("wrap_ffff", {48'h0, cnt_n}, 64'hFFFF);
        @(negedge clk);
        wb_en = 1'b1; dstE = 4'hA; valE = 64'h2; dstM = 4'hB; valM = 64'h3;
        step();
        check("wrap_1", {48'h0, cnt_b}, 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_file.md
Name: reg_file

Overview:
- Y86-64 program register file for the SEQ datapath; direct downstream consumer of the write-back destination selector.
- Holds 15 64-bit registers, %rax (0) through %r14 (14). Code 15 is RNONE: it never writes and always reads as zero.
- Two combinational read ports (srcA/srcB) feed the decode stage.
- Two synchronous write ports (E and M) commit valE and valM to dstE and dstM on the rising clock edge.

Parameters:
- DATA_W, 64, register width in bits.
- ADDR_W, 4, register specifier width.
- RNONE, 4'hF, "no register" specifier.
- RSP_INIT, 64'h0, reset value of %rsp (register 4).
- BYPASS, 0. When 1, a read of a register being written in the same cycle returns the write data (write-through). When 0, it returns the old value.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- wb_en  input  1  global write enable. 0 blocks both write ports (used on halt or exception status).
- dstE  input  ADDR_W  E-port destination specifier.
- valE  input  DATA_W  E-port write data.
- dstM  input  ADDR_W  M-port destination specifier.
- valM  input  DATA_W  M-port write data.
- srcA  input  ADDR_W  read port A specifier.
- srcB  input  ADDR_W  read port B specifier.
- valA  output  DATA_W  read port A data.
- valB  output  DATA_W  read port B data.
- dbg_sel  input  ADDR_W  debug read specifier.
- dbg_val  output  DATA_W  debug read data. Same rules as the A/B ports, never bypassed.
- wr_count  output  16  count of committed register writes.

Behaviour:
- Reset:
  - rst is sampled only at the rising edge of clk.
  - Reset sets every register to 0, except register 4 (%rsp), which takes RSP_INIT.
  - Reset sets wr_count to 0.
  - Reset overrides any write presented in the same cycle.
  - After reset, valA and valB read register contents (0, or RSP_INIT for specifier 4) combinationally.
- Reads:
  - Purely combinational, zero latency.
  - Specifier 15 returns 0.
  - Specifier 0..14 returns the stored value, subject to the BYPASS rule below.
- Writes:
  - Committed at the rising edge when wb_en=1 and rst=0.
  - E port writes when dstE != RNONE. M port writes when dstM != RNONE.
  - A write to specifier 15 is dropped silently.
- Write conflict (dstE == dstM != RNONE, e.g. popq %rsp):
  - The M port wins; the register takes valM.
  - The conflict counts as one committed write.
- wr_count:
  - Increments by the number of distinct registers written that cycle (0, 1 or 2).
  - Wraps from 16'hFFFF to 0.
  - Holds when wb_en=0.
- BYPASS=1:
  - A read on port A or B whose specifier matches an active write (wb_en=1, specifier != RNONE) returns that write's data combinationally.
  - If both write ports target the read specifier, valM is returned.
  - Bypass is inactive during rst.
- BYPASS=0: reads always return the pre-edge stored value.
- No X propagation: uninitialised read before the first reset is not a supported use. The bench must apply reset first.

Decomposition:
- Shared package y86_pkg:
  - register specifier constants: RAX..R14, RSP=4, RNONE=15.
  - DATA_W and ADDR_W.
  - type reg_id_t (4-bit) and word_t (64-bit).
- Sub-module reg_read_port: one combinational read-mux plus bypass compare.
  - Instantiated three times: A, B, and debug with bypass tied off.
- Storage array, write decode and counter live in reg_file.

Test Plan:
- Reset: assert rst for 1 cycle with RSP_INIT=64'h200 → valA=0 for srcA=0..14 except srcA=4 gives 64'h200; wr_count=0.
- Dual write:
  - Stimulus: dstE=2, valE=64'hAA; dstM=3, valM=64'hBB; wb_en=1; one edge.
  - Response: srcA=2 → 64'hAA, srcB=3 → 64'hBB, wr_count=2.
- Conflict:
  - Stimulus: dstE=4, valE=64'h1F8; dstM=4, valM=64'h55; one edge.
  - Response: reg 4 = 64'h55, wr_count increments by 1.
- RNONE and gating:
  - dstE=15, dstM=15 with wb_en=1 → no state change, wr_count unchanged.
  - dstE=1 with wb_en=0 → reg 1 unchanged.
  - srcA=15 always → 0.
- Bypass (BYPASS=1):
  - Stimulus: dstE=5, valE=64'h77, srcA=5, same cycle before the edge.
  - Response: valA=64'h77. With BYPASS=0, valA shows the old value until after the edge.
- Reset mid-stream: rst=1 together with dstE=6, valE=64'h9 → reg 6 = 0 after the edge; wr_count=0.
